mole_beat_scheduler: RTL
========================

Name: mole_beat_scheduler

Overview:
- Parametrised successor to the single-output mole trigger.
- Watches the audio playback address and, when it reaches each scheduled beat, queues a mole-spawn request with a target hole location.
- Beat table is either a compile-time preset or the user-entered DIY table.
- Requests are buffered in a small FIFO and handed to the mole spawner over a valid/ack handshake. Song restarts and table switches are handled explicitly.

Parameters:
NUM_BEATS, 6, entries in each beat table; index width = clog2(NUM_BEATS+1)
ADDR_W, 23, music address width
LOC_W, 4, hole-location code width
FIFO_DEPTH, 4, pending-request buffer depth (power of 2, >=2)
PRESET_ADDRS, 0, packed NUM_BEATS*ADDR_W preset beat addresses, entry i at [i*ADDR_W +: ADDR_W]
PRESET_LOCS, 0, packed NUM_BEATS*LOC_W preset locations, entry i at [i*LOC_W +: LOC_W]

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
music_address  input  ADDR_W  current playback sample address
using_diy  input  1  1 = use DIY table, 0 = preset table
diy_addresses  input  NUM_BEATS*ADDR_W  DIY beat addresses, same packing as PRESET_ADDRS
diy_locations  input  NUM_BEATS*LOC_W  DIY locations, same packing as PRESET_LOCS
mole_ack  input  1  spawner accepts head request this cycle
request_mole  output  1  FIFO non-empty (valid)
mole_location  output  LOC_W  location of head request; 0 when empty
pending_count  output  clog2(FIFO_DEPTH)+1  entries queued
overflow  output  1  sticky: a beat was dropped because FIFO full

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- Reset state:
  - ptr=0, prev_addr=0, diy_q=using_diy.
  - FIFO empty: request_mole=0, mole_location=0, pending_count=0, overflow=0.
- Beat tables are ascending by address. Unsorted tables are outside the contract: a later smaller entry fires immediately after its predecessor.
- Active table = DIY when diy_q=1, else preset.
- Match condition, evaluated combinationally on the current music_address: ptr<NUM_BEATS and music_address >= addr[ptr].
  - On match at edge N: push loc[ptr], ptr++. request_mole is high from cycle N+1 (1-cycle latency).
  - At most one beat per cycle. If the address jumps past k beats, they fire on k consecutive cycles, in order.
  - ptr==NUM_BEATS: song exhausted, no further pushes until re-arm.
- Wrap / restart: music_address < prev_addr forces ptr<=0 with no push that cycle. The FIFO is kept. Matching resumes next cycle. prev_addr <= music_address every cycle.
- Table switch: using_diy != diy_q forces ptr<=0 and flushes the FIFO (count 0, request_mole 0 next cycle), then diy_q<=using_diy. No push that cycle. overflow is not cleared.
- Priority: reset > table switch > wrap > match.
- FIFO:
  - pop when request_mole && mole_ack; ack while empty is ignored.
  - Push and pop in the same cycle are both performed, count unchanged. This holds when full and when count is 1.
  - Push when full without pop: entry dropped, ptr still advances, overflow<=1 until reset.
  - mole_location is the registered head entry (mux from storage), valid whenever request_mole=1.
- Beat address 0 fires on the first cycle after reset if music_address>=0, i.e. always.

Test Plan:
- Preset {0x6CDF loc 2, 0x8B01 loc 5, rest 0x7FFFFF}, using_diy=0. Drive addr 0, 0x6CDE, 0x6CDF, 0x8B00, 0x8B01, one per cycle, mole_ack=1.
  -> request_mole high exactly one cycle after 0x6CDF (loc 2) and one cycle after 0x8B01 (loc 5); nothing else.
- Same table, mole_ack=0, addr jumps 0 -> 0x9000.
  -> pushes on two consecutive cycles; pending_count=2; head loc 2, then loc 5 after one ack.
- Addr runs past both beats, then drops to 0x0010, then rises to 0x6CDF.
  -> ptr re-arms; loc 2 queued again; no spurious push on the drop cycle.
- DIY table with 6 beats all at 0x0100, FIFO_DEPTH=4, mole_ack=0, addr=0x0200.
  -> 4 entries queued, overflow=1 after the 5th beat; ptr reaches 6.
- Queue holds 2 entries; toggle using_diy.
  -> next cycle request_mole=0, pending_count=0; DIY beats then fire from entry 0.
- Reset asserted mid-queue with mole_ack=1.
  -> next cycle all outputs 0, overflow cleared.

Source files
------------

// File: rtl/mole_beat_scheduler.sv
// Beat scheduler: queues a mole-spawn request each time the playback address reaches the next beat
// of the active table (preset or DIY), and hands the requests out over a valid/ack FIFO.
module mole_beat_scheduler #(
  parameter int unsigned NUM_BEATS  = 6,
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned LOC_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [NUM_BEATS*ADDR_W-1:0] PRESET_ADDRS = '0,
  parameter logic [NUM_BEATS*LOC_W-1:0]  PRESET_LOCS  = '0,
  localparam int unsigned IW = $clog2(NUM_BEATS + 1),
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             music_address,
  input  logic                          using_diy,
  input  logic [NUM_BEATS*ADDR_W-1:0]   diy_addresses,
  input  logic [NUM_BEATS*LOC_W-1:0]    diy_locations,
  input  logic                          mole_ack,
  output logic                          request_mole,
  output logic [LOC_W-1:0]              mole_location,
  output logic [CW-1:0]                 pending_count,
  output logic                          overflow
);

  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned TBL_N = 1 << IW;

  logic [IW-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0] prev_addr_q;
  logic              diy_q, diy_d;
  logic [LOC_W-1:0]  mem_q [FIFO_DEPTH];
  logic [LOC_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [LOC_W-1:0]  loc_q, loc_d;
  logic              ovf_q, ovf_d;

  logic              tbl_switch, wrap, match, push, pop, full, accept;

  // Active table, padded to a power-of-two depth so ptr always indexes in range
  logic [ADDR_W-1:0] addr_tbl [TBL_N];
  logic [LOC_W-1:0]  loc_tbl  [TBL_N];

  for (genvar g = 0; g < TBL_N; g++) begin : g_tbl
    if (g < NUM_BEATS) begin : g_real
      assign addr_tbl[g] = diy_q ? diy_addresses[g*ADDR_W +: ADDR_W]
                                 : PRESET_ADDRS[g*ADDR_W +: ADDR_W];
      assign loc_tbl[g]  = diy_q ? diy_locations[g*LOC_W +: LOC_W]
                                 : PRESET_LOCS[g*LOC_W +: LOC_W];
    end else begin : g_pad
      assign addr_tbl[g] = '0;
      assign loc_tbl[g]  = '0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    diy_d = diy_q;
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;

    tbl_switch = (using_diy != diy_q);
    wrap       = (music_address < prev_addr_q);
    match      = (ptr_q < IW'(NUM_BEATS)) && (music_address >= addr_tbl[ptr_q]);
    push       = match && !tbl_switch && !wrap;
    pop        = req_q && mole_ack && !tbl_switch;
    full       = (cnt_q == CW'(FIFO_DEPTH));
    accept     = push && (!full || pop);

    if (tbl_switch) begin
      // New table: re-arm from entry 0 and discard requests from the old table
      ptr_d = '0;
      diy_d = using_diy;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (wrap) begin
        ptr_d = '0;
      end else if (match) begin
        ptr_d = ptr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      if (accept) begin
        mem_d[wr_q] = loc_tbl[ptr_q];
        wr_d        = wr_q + 1'b1;
      end else if (push) begin
        ovf_d = 1'b1;
      end
      case ({accept, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    // Head is taken from next-state storage so a push into an empty queue is visible at once
    req_d = (cnt_d != '0);
    loc_d = req_d ? mem_d[rd_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      prev_addr_q <= '0;
      diy_q       <= using_diy;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      loc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      prev_addr_q <= music_address;
      diy_q       <= diy_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      loc_q       <= loc_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign request_mole  = req_q;
  assign mole_location = loc_q;
  assign pending_count = cnt_q;
  assign overflow      = ovf_q;

endmodule
